// File: rtl/mem_sram_ctrl_pkg.sv
// rtl/mem_sram_ctrl_pkg.sv - MEM-stage op codes, SRAM FSM states and op classifiers
// Purpose: shared encodings for the data-memory SRAM controller and its lane aligner.
package mem_sram_ctrl_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef enum logic [2:0] {
    SRAM_IDLE  = 3'd0,
    SRAM_READ  = 3'd1,
    SRAM_WRITE = 3'd2,
    SRAM_WHOLD = 3'd3,
    SRAM_DONE  = 3'd4
  } sram_state_e;

  // Unknown codes fall out of both classifiers and so behave as NOP.
  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// rtl/mem_sram_ctrl_if.sv - MEM stage <-> SRAM controller request/response bundle
// Purpose: groups the MEM-side op, address, store data, load result and stall.
// master = MEM stage (drives op/addr/data), slave = controller (drives load data/stall).
interface mem_sram_ctrl_if;
  logic [3:0]  ramOp_i;
  logic [31:0] ramAddr_i;
  logic [31:0] storeData_i;
  logic [31:0] load_data_o;
  logic        stall_o;

  modport master (
    output ramOp_i, ramAddr_i, storeData_i,
    input  load_data_o, stall_o
  );

  modport slave (
    input  ramOp_i, ramAddr_i, storeData_i,
    output load_data_o, stall_o
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication and load extension
// Purpose: purely combinational lane logic for a 32-bit little-endian word bus.
// Ports: i_op (MEM op), i_a (byte offset), i_store_data (right-aligned), i_rdata (bus word)
//        -> o_be_n (active-low lane enables), o_wdata (lane-replicated), o_load_ext.
module mem_lane_align
  import mem_sram_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be_n,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_ext
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rdata >> {i_a, 3'b000};
  assign w_byte  = w_shift[7:0];
  // a[0] is deliberately ignored for halves so a stray misaligned op stays in-word.
  assign w_half  = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be_n     = 4'hF;
    o_wdata    = i_store_data;
    o_load_ext = 32'h0;
    case (i_op)
      MEM_LB:  begin o_be_n = ~(4'b0001 << i_a); o_load_ext = {{24{w_byte[7]}}, w_byte}; end
      MEM_LBU: begin o_be_n = ~(4'b0001 << i_a); o_load_ext = {24'h0, w_byte}; end
      MEM_LH:  begin o_be_n = i_a[1] ? 4'b0011 : 4'b1100; o_load_ext = {{16{w_half[15]}}, w_half}; end
      MEM_LHU: begin o_be_n = i_a[1] ? 4'b0011 : 4'b1100; o_load_ext = {16'h0, w_half}; end
      MEM_LW:  begin o_be_n = 4'b0000; o_load_ext = i_rdata; end
      MEM_SB:  begin o_be_n = ~(4'b0001 << i_a); o_wdata = {4{i_store_data[7:0]}}; end
      MEM_SH:  begin o_be_n = i_a[1] ? 4'b0011 : 4'b1100; o_wdata = {2{i_store_data[15:0]}}; end
      MEM_SW:  begin o_be_n = 4'b0000; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - MEM-stage responder running multi-cycle async SRAM accesses
// Purpose: accepts a load/store from MEM, strobes an external 32-bit SRAM for WAIT_CYCLES,
// returns extended load data and stalls the pipeline until the access is done.
// Ports: clk, rst (async active-low), mem (slave side of mem_sram_ctrl_if),
//        sram_* pins: word address, replicated write data, read data, bus drive enable,
//        active-low byte enables / chip enable / output enable / write enable.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_sram_ctrl_if.slave    mem,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic              sram_data_oe_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  sram_state_e       r_state;
  logic [3:0]        r_cnt;
  logic [3:0]        r_op;
  logic [1:0]        r_a;
  logic [31:0]       r_load;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be_n;
  logic              r_ce_n, r_oe_n, r_we_n, r_data_oe;

  logic [3:0]        w_op;
  logic [1:0]        w_a;
  logic [3:0]        w_be_n;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_ext;
  logic              w_unused;

  // Live inputs steer the aligner while idle; the latched op/offset drive it during the
  // access so load extension never depends on MEM holding its inputs.
  assign w_op = (r_state == SRAM_IDLE) ? mem.ramOp_i : r_op;
  assign w_a  = (r_state == SRAM_IDLE) ? mem.ramAddr_i[1:0] : r_a;
  assign w_unused = ^mem.ramAddr_i[31:ADDR_W+2];

  mem_lane_align u_lane_align (
    .i_op         (w_op),
    .i_a          (w_a),
    .i_store_data (mem.storeData_i),
    .i_rdata      (sram_rdata_i),
    .o_be_n       (w_be_n),
    .o_wdata      (w_wdata),
    .o_load_ext   (w_load_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SRAM_IDLE;
      r_cnt     <= 4'd0;
      r_op      <= MEM_NOP;
      r_a       <= 2'd0;
      r_load    <= 32'h0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_be_n    <= 4'hF;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_data_oe <= 1'b0;
    end else begin
      case (r_state)
        SRAM_IDLE: begin
          if (is_load(mem.ramOp_i) || is_store(mem.ramOp_i)) begin
            r_addr  <= mem.ramAddr_i[ADDR_W+1:2];
            r_be_n  <= w_be_n;
            r_wdata <= w_wdata;
            r_cnt   <= CNT_INIT;
            r_op    <= mem.ramOp_i;
            r_a     <= mem.ramAddr_i[1:0];
            r_ce_n  <= 1'b0;
            if (is_load(mem.ramOp_i)) begin
              r_state <= SRAM_READ;
              r_oe_n  <= 1'b0;
            end else begin
              r_state   <= SRAM_WRITE;
              r_we_n    <= 1'b0;
              r_data_oe <= 1'b1;
            end
          end
        end
        SRAM_READ: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_load  <= w_load_ext;
            r_state <= SRAM_DONE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_be_n  <= 4'hF;
          end
        end
        SRAM_WRITE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Rising we_n here; chip select and data stay up one more cycle for hold time.
            r_state <= SRAM_WHOLD;
            r_we_n  <= 1'b1;
          end
        end
        SRAM_WHOLD: begin
          r_state   <= SRAM_DONE;
          r_ce_n    <= 1'b1;
          r_data_oe <= 1'b0;
          r_be_n    <= 4'hF;
        end
        SRAM_DONE: r_state <= SRAM_IDLE;
        default:   r_state <= SRAM_IDLE;
      endcase
    end
  end

  assign mem.stall_o = ((r_state == SRAM_IDLE) &&
                        (is_load(mem.ramOp_i) || is_store(mem.ramOp_i))) ||
                       (r_state == SRAM_READ) || (r_state == SRAM_WRITE) ||
                       (r_state == SRAM_WHOLD);
  assign mem.load_data_o = r_load;

  assign sram_addr_o    = r_addr;
  assign sram_wdata_o   = r_wdata;
  assign sram_data_oe_o = r_data_oe;
  assign sram_be_n_o    = r_be_n;
  assign sram_ce_n_o    = r_ce_n;
  assign sram_oe_n_o    = r_oe_n;
  assign sram_we_n_o    = r_we_n;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - self-checking bench for mem_sram_ctrl with async SRAM models
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  mem_sram_ctrl_if if0 ();
  mem_sram_ctrl_if if1 ();

  logic [3:0]  t_op;
  logic [31:0] t_addr, t_data;
  bit          cur;

  assign if0.ramOp_i     = cur ? MEM_NOP : t_op;
  assign if1.ramOp_i     = cur ? t_op : MEM_NOP;
  assign if0.ramAddr_i   = t_addr;
  assign if1.ramAddr_i   = t_addr;
  assign if0.storeData_i = t_data;
  assign if1.storeData_i = t_data;

  logic [19:0] s0_addr, s1_addr;
  logic [31:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata;
  logic        s0_doe, s1_doe, s0_ce_n, s1_ce_n, s0_oe_n, s1_oe_n, s0_we_n, s1_we_n;
  logic [3:0]  s0_be_n, s1_be_n;

  mem_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .mem(if0),
    .sram_addr_o(s0_addr), .sram_wdata_o(s0_wdata), .sram_rdata_i(s0_rdata),
    .sram_data_oe_o(s0_doe), .sram_be_n_o(s0_be_n), .sram_ce_n_o(s0_ce_n),
    .sram_oe_n_o(s0_oe_n), .sram_we_n_o(s0_we_n)
  );

  mem_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .mem(if1),
    .sram_addr_o(s1_addr), .sram_wdata_o(s1_wdata), .sram_rdata_i(s1_rdata),
    .sram_data_oe_o(s1_doe), .sram_be_n_o(s1_be_n), .sram_ce_n_o(s1_ce_n),
    .sram_oe_n_o(s1_oe_n), .sram_we_n_o(s1_we_n)
  );

  // Async SRAM models: read data is combinational, writes land per enabled lane.
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  assign s0_rdata = (!s0_ce_n && !s0_oe_n) ? mem0[s0_addr[5:0]] : 32'h0;
  assign s1_rdata = (!s1_ce_n && !s1_oe_n) ? mem1[s1_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (!s0_ce_n && !s0_we_n && s0_doe)
      for (int i = 0; i < 4; i++) if (!s0_be_n[i]) mem0[s0_addr[5:0]][8*i +: 8] = s0_wdata[8*i +: 8];
    if (!s1_ce_n && !s1_we_n && s1_doe)
      for (int j = 0; j < 4; j++) if (!s1_be_n[j]) mem1[s1_addr[5:0]][8*j +: 8] = s1_wdata[8*j +: 8];
  end

  int acc0 = 0;
  int acc1 = 0;
  always @(negedge s0_ce_n) acc0++;
  always @(negedge s1_ce_n) acc1++;

  logic        w_stall, w_ce, w_we;
  logic [31:0] w_load, w_wdata;
  logic [3:0]  w_be;
  logic [19:0] w_addr;
  assign w_stall = cur ? if1.stall_o : if0.stall_o;
  assign w_load  = cur ? if1.load_data_o : if0.load_data_o;
  assign w_ce    = cur ? s1_ce_n : s0_ce_n;
  assign w_we    = cur ? s1_we_n : s0_we_n;
  assign w_be    = cur ? s1_be_n : s0_be_n;
  assign w_addr  = cur ? s1_addr : s0_addr;
  assign w_wdata = cur ? s1_wdata : s0_wdata;

  logic [31:0] exp_q [$];
  logic [19:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  int          we_low;

  task automatic run_op(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, output int n);
    logic [31:0] exp;
    @(negedge clk);
    cur = sel; t_op = op; t_addr = addr; t_data = data;
    n = 0; we_low = 0; cap_addr = '0; cap_be = 4'hF; cap_wdata = '0;
    #1;
    while (w_stall && n < 64) begin
      n++;
      if (!w_ce) begin cap_addr = w_addr; cap_be = w_be; cap_wdata = w_wdata; end
      if (!w_we) we_low++;
      @(negedge clk); #1;
    end
    if (n >= 64) begin
      checks++; errors++;
      $display("FAIL stall_timeout op=%0d got stall stuck high, required release", op);
    end
    if (op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW}) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty op=%0d load_data=%h", op, w_load);
      end else begin
        exp = exp_q.pop_front();
        if (w_load !== exp) begin
          errors++;
          $display("FAIL load_data op=%0d addr=%h got %h required %h", op, addr, w_load, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cur = 1'b0; t_op = MEM_NOP; t_addr = '0; t_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({s0_ce_n, s0_oe_n, s0_we_n, s0_be_n, s0_doe} !== 8'b1111_1110) begin
      errors++; $display("FAIL reset_strobes got %b required 11111110", {s0_ce_n, s0_oe_n, s0_we_n, s0_be_n, s0_doe});
    end
    checks++;
    if ({s0_addr, s0_wdata, if0.load_data_o} !== 84'h0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h required 0", s0_addr, s0_wdata, if0.load_data_o);
    end
    checks++;
    if (if0.stall_o !== 1'b0 || if1.stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b%b required 00", if0.stall_o, if1.stall_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_store_word();
    int n;
    run_op(0, MEM_SW, 32'h10, 32'hDEADBEEF, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL sw_stall got %0d required 3", n); end
    checks++;
    if (cap_addr !== 20'h4 || cap_be !== 4'b0000 || cap_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_bus got addr=%h be=%b wd=%h required 4/0000/deadbeef", cap_addr, cap_be, cap_wdata);
    end
    checks++;
    if (we_low != 1) begin errors++; $display("FAIL sw_we_low got %0d required 1", we_low); end
  endtask

  task automatic test_load_word();
    int n;
    exp_q.push_back(32'hDEADBEEF);
    run_op(0, MEM_LW, 32'h10, 32'h0, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL lw_stall got %0d required 2", n); end
  endtask

  task automatic test_load_ext();
    logic [3:0]  ops  [4] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    int n;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(exps[k]);
      run_op(0, ops[k], adrs[k], 32'h0, n);
    end
  endtask

  task automatic test_store_byte();
    int n;
    run_op(0, MEM_SB, 32'h11, 32'h000000AA, n);
    checks++;
    if (cap_be !== 4'b1101 || cap_wdata !== 32'hAAAAAAAA) begin
      errors++; $display("FAIL sb_lane got be=%b wd=%h required 1101/aaaaaaaa", cap_be, cap_wdata);
    end
    exp_q.push_back(32'hDEADAAEF);
    run_op(0, MEM_LW, 32'h10, 32'h0, n);
  endtask

  task automatic test_bad_op();
    int a0;
    int bad;
    @(negedge clk);
    cur = 0; t_op = MEM_NOP;
    a0 = acc0; bad = 0;
    @(negedge clk);
    t_op = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1; if (if0.stall_o !== 1'b0) bad++;
      @(negedge clk);
    end
    t_op = MEM_NOP;
    checks++;
    if (bad != 0 || acc0 != a0) begin
      errors++; $display("FAIL unknown_op got stalls=%0d accesses=%0d required 0/0", bad, acc0 - a0);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    @(negedge clk);
    cur = 0; t_op = MEM_LW; t_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (s0_ce_n !== 1'b0 || s0_oe_n !== 1'b0) begin
      errors++; $display("FAIL mid_read_entry got ce_n=%b oe_n=%b required 0/0", s0_ce_n, s0_oe_n);
    end
    rst = 1'b0; t_op = MEM_NOP;
    #1;
    checks++;
    if ({s0_ce_n, s0_oe_n, s0_we_n, s0_be_n, if0.stall_o} !== 8'b1111_1110) begin
      errors++; $display("FAIL abort_strobes got %b required 11111110", {s0_ce_n, s0_oe_n, s0_we_n, s0_be_n, if0.stall_o});
    end
    checks++;
    if (if0.load_data_o !== 32'h0) begin
      errors++; $display("FAIL abort_load got %h required 0", if0.load_data_o);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(32'hDEADAAEF);
    run_op(0, MEM_LW, 32'h10, 32'h0, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL post_abort_stall got %0d required 2", n); end
  endtask

  task automatic test_back_to_back();
    int n1, n2, n3, a1;
    a1 = acc1;
    exp_q.push_back(32'h10000008);
    run_op(1, MEM_LW, 32'h20, 32'h0, n1);
    run_op(1, MEM_SW, 32'h20, 32'hCAFEF00D, n2);
    exp_q.push_back(32'hCAFEF00D);
    run_op(1, MEM_LW, 32'h20, 32'h0, n3);
    checks++;
    if (n1 != 4 || n2 != 5 || n3 != 4) begin
      errors++; $display("FAIL b2b_stall got %0d,%0d,%0d required 4,5,4", n1, n2, n3);
    end
    @(negedge clk);
    t_op = MEM_NOP;
    repeat (3) @(negedge clk);
    checks++;
    if (acc1 - a1 != 3) begin
      errors++; $display("FAIL b2b_accesses got %0d required 3", acc1 - a1);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h10000000 + i;
    end
    test_reset();
    test_store_word();
    test_load_word();
    test_load_ext();
    test_store_byte();
    test_bad_op();
    test_reset_mid_read();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
